// File: rtl/svm_pkg.sv
// Shared types and helpers for the streaming SVM classifier: FSM state encoding,
// output field layout, default widths and the score saturation function.
package svm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        ARGMAX,
        OUT
    } state_t;

    localparam int CLASS_LSB   = 24;
    localparam int SCORE_LSB   = 0;

    localparam int DEF_FEAT_W  = 16;
    localparam int DEF_ACC_W   = 48;
    localparam int DEF_SCORE_W = 24;

    // Symmetric clamp to +/-(2^(width-1)-1); result is in the low width bits.
    function automatic logic [31:0] saturate(input logic signed [63:0] value, input int width);
        logic signed [63:0] lim;
        logic signed [63:0] res;
        lim = (64'sd1 <<< (width - 1)) - 64'sd1;
        res = value;
        if (value > lim) begin
            res = lim;
        end else if (value < -lim) begin
            res = -lim;
        end
        return res[31:0];
    endfunction

endpackage

// File: rtl/svm_mac_lane.sv
// One class lane: registered signed multiply, then sign-extended accumulate on
// the following cycle. Accumulator wraps modulo 2^ACC_W.
module svm_mac_lane
    import svm_pkg::*;
#(
    parameter int FEAT_W = DEF_FEAT_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [FEAT_W-1:0] weight,
    input  logic [FEAT_W-1:0] feature,
    output logic [ACC_W-1:0]  acc
);

    logic signed [2*FEAT_W-1:0] prod;
    logic                       prod_vld;

    // prod_vld tracks whether the registered product belongs to an accepted beat,
    // so idle cycles and discarded over-length beats never reach the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else if (clr) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            if (prod_vld) begin
                acc <= acc + ACC_W'(prod);
            end
            prod     <= (2*FEAT_W)'($signed(weight)) * (2*FEAT_W)'($signed(feature));
            prod_vld <= en;
        end
    end

endmodule

// File: rtl/svm_stream_classifier.sv
// Streaming one-vs-rest linear SVM: N_CLASS MAC lanes, runtime weights, sequential argmax.
// Optional performance counters are compiled in with SVM_STREAM_PERF_EN.
module svm_stream_classifier
    import svm_pkg::*;
#(
    parameter int FEAT_W  = DEF_FEAT_W,
    parameter int N_FEAT  = 32,
    parameter int N_CLASS = 4,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SCORE_W = DEF_SCORE_W
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [31:0]               input_r_TDATA,
    input  logic                      input_r_TVALID,
    input  logic                      input_r_TLAST,
    output logic                      input_r_TREADY,
    output logic [31:0]               output_r_TDATA,
    output logic                      output_r_TVALID,
    input  logic                      output_r_TREADY,
    input  logic                      cfg_we,
    input  logic [3:0]                cfg_class,
    input  logic [$clog2(N_FEAT):0]   cfg_idx,
    input  logic [31:0]               cfg_data,
    output logic                      cfg_ready,
    output logic                      len_err,
    output logic                      interrupt
`ifdef SVM_STREAM_PERF_EN
    ,
    output logic [31:0]               perf_frames,
    output logic [31:0]               perf_stall
`endif
);

    localparam int FW   = $clog2(N_FEAT);
    localparam int CW   = $clog2(N_CLASS);
    localparam int IDXW = FW + 1;

    localparam logic [IDXW-1:0] NF      = IDXW'(N_FEAT);
    localparam logic [IDXW-1:0] NF_LAST = IDXW'(N_FEAT - 1);
    localparam logic [CW-1:0]   NC_LAST = CW'(N_CLASS - 1);
    localparam logic [4:0]      NC5     = 5'(N_CLASS);

    generate
        if (ACC_W < 2*FEAT_W + $clog2(N_FEAT) + 1 || ACC_W > 64) begin : g_bad_acc_w
            $error("ACC_W too small for FEAT_W/N_FEAT or wider than 64");
        end
        if (N_CLASS < 2 || N_CLASS > 16 || N_FEAT < 2) begin : g_bad_shape
            $error("N_CLASS must be 2..16 and N_FEAT >= 2");
        end
        if (SCORE_W > 24 || SCORE_W < 2 || FEAT_W > 16 || FEAT_W < 2) begin : g_bad_width
            $error("SCORE_W must be 2..24 and FEAT_W 2..16");
        end
    endgenerate

    state_t state, state_nxt;

    logic [FEAT_W-1:0]        w_mem    [N_CLASS][N_FEAT];
    logic [ACC_W-1:0]         bias_mem [N_CLASS];
    logic [ACC_W-1:0]         acc_all  [N_CLASS];

    logic [IDXW-1:0]          cnt;
    logic [CW-1:0]            arg_cnt;
    logic [CW-1:0]            best_idx;
    logic signed [ACC_W-1:0]  best_score;
    logic signed [ACC_W-1:0]  cand;
    logic signed [63:0]       best_ext;
    logic [31:0]              sat;

    logic                     beat;
    logic                     mac_en;
    logic                     done_hs;
    logic                     cfg_ok;
    logic [FW-1:0]            feat_sel;
    logic                     unused_bits;

    assign beat     = input_r_TVALID & input_r_TREADY;
    assign mac_en   = beat && (cnt < NF);
    assign feat_sel = mac_en ? cnt[FW-1:0] : '0;
    assign done_hs  = output_r_TVALID & output_r_TREADY;
    assign cfg_ok   = cfg_we && cfg_ready && ({1'b0, cfg_class} < NC5) && (cfg_idx <= NF);

    assign unused_bits = ^{input_r_TDATA[31:FEAT_W], sat[31:SCORE_W]};

    // Coefficient storage keeps its contents across reset so a host can reset
    // the stream path without reloading the model.
    always_ff @(posedge ap_clk) begin
        if (cfg_ok) begin
            if (cfg_idx == NF) begin
                bias_mem[cfg_class[CW-1:0]] <= ACC_W'($signed(cfg_data));
            end else begin
                w_mem[cfg_class[CW-1:0]][cfg_idx[FW-1:0]] <= cfg_data[FEAT_W-1:0];
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat) state_nxt = input_r_TLAST ? DRAIN : ACCUM;
            ACCUM:   if (beat && input_r_TLAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = ARGMAX;
            ARGMAX:  if (arg_cnt == NC_LAST) state_nxt = OUT;
            OUT:     if (output_r_TREADY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are held low while reset is asserted.
    always_comb begin
        input_r_TREADY  = 1'b0;
        cfg_ready       = 1'b0;
        output_r_TVALID = 1'b0;
        interrupt       = 1'b0;
        if (!ap_rst) begin
            case (state)
                IDLE: begin
                    input_r_TREADY = 1'b1;
                    cfg_ready      = 1'b1;
                end
                ACCUM:   input_r_TREADY = 1'b1;
                OUT: begin
                    output_r_TVALID = 1'b1;
                    interrupt       = output_r_TREADY;
                end
                default: ;
            endcase
        end
    end

    // Feature counter saturates at N_FEAT so over-length beats stop feeding the MACs.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt     <= '0;
            len_err <= 1'b0;
        end else if (beat) begin
            if (input_r_TLAST) begin
                cnt <= '0;
                if (cnt != NF_LAST) begin
                    len_err <= 1'b1;
                end
            end else if (cnt < NF) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar c = 0; c < N_CLASS; c++) begin : g_lane
            svm_mac_lane #(
                .FEAT_W (FEAT_W),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clk     (ap_clk),
                .rst     (ap_rst),
                .clr     (done_hs),
                .en      (mac_en),
                .weight  (w_mem[c][feat_sel]),
                .feature (input_r_TDATA[FEAT_W-1:0]),
                .acc     (acc_all[c])
            );
        end
    endgenerate

    assign cand = acc_all[arg_cnt] + bias_mem[arg_cnt];

    // Class 0 seeds the running best; later classes replace it only when strictly
    // greater, which gives ties to the lowest index.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            arg_cnt    <= '0;
            best_idx   <= '0;
            best_score <= '0;
        end else if (state == ARGMAX) begin
            arg_cnt <= arg_cnt + 1'b1;
            if (arg_cnt == '0 || cand > best_score) begin
                best_idx   <= arg_cnt;
                best_score <= cand;
            end
        end else begin
            arg_cnt <= '0;
        end
    end

    always_comb begin
        best_ext       = 64'(best_score);
        sat            = saturate(best_ext, SCORE_W);
        output_r_TDATA = '0;
        output_r_TDATA[CLASS_LSB +: 8]       = 8'(best_idx);
        output_r_TDATA[SCORE_LSB +: SCORE_W] = sat[SCORE_W-1:0];
    end

`ifdef SVM_STREAM_PERF_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            perf_frames <= '0;
            perf_stall  <= '0;
        end else begin
            if (done_hs) begin
                perf_frames <= perf_frames + 32'd1;
            end
            if (output_r_TVALID && !output_r_TREADY) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_svm_stream_classifier.sv
// Self-checking bench for svm_stream_classifier (N_FEAT=4, N_CLASS=2): directed
// table, multi-cycle corner sequences and randomized frames against a reference model.
module tb_svm_stream_classifier;

    localparam int FEAT_W  = 16;
    localparam int N_FEAT  = 4;
    localparam int N_CLASS = 2;
    localparam int ACC_W   = 48;
    localparam int SCORE_W = 24;
    localparam int IDXW    = $clog2(N_FEAT) + 1;

    logic            ap_clk = 1'b0;
    logic            ap_rst;
    logic [31:0]     input_r_TDATA;
    logic            input_r_TVALID;
    logic            input_r_TLAST;
    logic            input_r_TREADY;
    logic [31:0]     output_r_TDATA;
    logic            output_r_TVALID;
    logic            output_r_TREADY;
    logic            cfg_we;
    logic [3:0]      cfg_class;
    logic [IDXW-1:0] cfg_idx;
    logic [31:0]     cfg_data;
    logic            cfg_ready;
    logic            len_err;
    logic            interrupt;

    svm_stream_classifier #(
        .FEAT_W  (FEAT_W),
        .N_FEAT  (N_FEAT),
        .N_CLASS (N_CLASS),
        .ACC_W   (ACC_W),
        .SCORE_W (SCORE_W)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .input_r_TDATA   (input_r_TDATA),
        .input_r_TVALID  (input_r_TVALID),
        .input_r_TLAST   (input_r_TLAST),
        .input_r_TREADY  (input_r_TREADY),
        .output_r_TDATA  (output_r_TDATA),
        .output_r_TVALID (output_r_TVALID),
        .output_r_TREADY (output_r_TREADY),
        .cfg_we          (cfg_we),
        .cfg_class       (cfg_class),
        .cfg_idx         (cfg_idx),
        .cfg_data        (cfg_data),
        .cfg_ready       (cfg_ready),
        .len_err         (len_err),
        .interrupt       (interrupt)
    );

    // ---------------- clock / reset ----------------
    always #5 ap_clk = ~ap_clk;

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    int          mw[N_CLASS][N_FEAT];
    longint      mb[N_CLASS];

    typedef struct {
        int          nb;
        int          f[6];
        logic [31:0] exp;
        bit          lerr;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int cls, input longint score);
        logic [31:0] cv;
        logic [63:0] sv;
        cv = cls;
        sv = score;
        return {cv[7:0], sv[23:0]};
    endfunction

    function automatic vec_t mk(input int nb, input int a, input int b, input int c,
                                input int d, input int e, input int g,
                                input int cls, input int sc, input bit le);
        vec_t v;
        v.nb = nb;
        v.f[0] = a; v.f[1] = b; v.f[2] = c; v.f[3] = d; v.f[4] = e; v.f[5] = g;
        v.exp  = pack(cls, sc);
        v.lerr = le;
        return v;
    endfunction

    // Reference: score_c = bias_c + sum of w_c[i]*f[i] over the first N_FEAT
    // features actually sent, wrapped to ACC_W; strict argmax; symmetric clamp.
    function automatic logic [31:0] model(input int feats[$]);
        longint s, best_s, lim;
        int     best_c;
        best_s = 0;
        best_c = 0;
        for (int c = 0; c < N_CLASS; c++) begin
            s = mb[c];
            for (int i = 0; i < feats.size() && i < N_FEAT; i++) begin
                s += longint'(mw[c][i]) * longint'(feats[i]);
            end
            s = (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
            if (c == 0 || s > best_s) begin
                best_s = s;
                best_c = c;
            end
        end
        lim = (longint'(1) <<< (SCORE_W - 1)) - 1;
        if (best_s > lim) best_s = lim;
        else if (best_s < -lim) best_s = -lim;
        return pack(best_c, best_s);
    endfunction

    // ---------------- driver tasks ----------------
    // Tasks start and end 1 time unit after a rising edge.
    task automatic cfg_write(input int c, input int idx, input logic [31:0] d, input bit idle);
        logic signed [15:0] ws;
        logic signed [31:0] bs;
        cfg_we    = 1'b1;
        cfg_class = c[3:0];
        cfg_idx   = idx[IDXW-1:0];
        cfg_data  = d;
        if (idle && c < N_CLASS && idx <= N_FEAT) begin
            ws = d[15:0];
            bs = d;
            if (idx == N_FEAT) mb[c] = bs;
            else mw[c][idx] = ws;
        end
        @(posedge ap_clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic load_model(input int w0[4], input int w1[4], input int b0, input int b1);
        for (int i = 0; i < N_FEAT; i++) begin
            cfg_write(0, i, w0[i], 1'b1);
            cfg_write(1, i, w1[i], 1'b1);
        end
        cfg_write(0, N_FEAT, b0, 1'b1);
        cfg_write(1, N_FEAT, b1, 1'b1);
    endtask

    task automatic run_frame(input int feats[$], input int stall);
        int          lat;
        int          fv;
        logic [31:0] r;
        logic [31:0] exp;
        for (int i = 0; i < feats.size(); i++) begin
            r  = $urandom;
            fv = feats[i];
            input_r_TVALID = 1'b1;
            input_r_TLAST  = (i == feats.size() - 1);
            input_r_TDATA  = {r[31:16], fv[15:0]};
            if (i == 0) check("in_ready", input_r_TREADY, 1);
            @(posedge ap_clk); #1;
        end
        input_r_TVALID = 1'b0;
        input_r_TLAST  = 1'b0;
        lat = 0;
        while (output_r_TVALID !== 1'b1 && lat < 40) begin
            @(posedge ap_clk); #1;
            lat++;
        end
        check("latency", lat, N_CLASS + 1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check("tdata", output_r_TDATA, exp);
        for (int s = 0; s < stall; s++) begin
            check("stall_tdata", output_r_TDATA, exp);
            check("stall_tvalid", output_r_TVALID, 1);
            check("stall_in_ready", input_r_TREADY, 0);
            check("stall_cfg_ready", cfg_ready, 0);
            check("stall_irq", interrupt, 0);
            if (s == 4) cfg_write(0, 0, 32'd77, 1'b0);
            else begin
                @(posedge ap_clk); #1;
            end
        end
        output_r_TREADY = 1'b1;
        #1;
        check("irq", interrupt, 1);
        @(posedge ap_clk); #1;
        output_r_TREADY = 1'b0;
        check("irq_clear", interrupt, 0);
        check("tvalid_clear", output_r_TVALID, 0);
    endtask

    // ---------------- test ----------------
    initial begin
        int q[$];
        int base0[4];
        int base1[4];
        int rw0[4];
        int rw1[4];

        base0 = '{1, 1, 1, 1};
        base1 = '{2, 0, 0, 0};
        tbl[0] = mk(4, 3, 1, 1, 1, 0, 0, 0, 6, 1'b0);
        tbl[1] = mk(4, 5, 0, 0, 0, 0, 0, 1, 10, 1'b0);
        tbl[2] = mk(4, 2, 0, 0, 0, 0, 0, 1, 4, 1'b0);
        tbl[3] = mk(4, 2, 1, 1, 0, 0, 0, 0, 4, 1'b0);
        tbl[4] = mk(2, 3, 1, 0, 0, 0, 0, 1, 6, 1'b1);
        tbl[5] = mk(6, 1, 1, 1, 1, 9, 9, 0, 4, 1'b1);

        ap_rst          = 1'b1;
        input_r_TDATA   = '0;
        input_r_TVALID  = 1'b0;
        input_r_TLAST   = 1'b0;
        output_r_TREADY = 1'b0;
        cfg_we          = 1'b0;
        cfg_class       = '0;
        cfg_idx         = '0;
        cfg_data        = '0;

        #12;
        check("rst_in_ready", input_r_TREADY, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_tvalid", output_r_TVALID, 0);
        check("rst_tdata", output_r_TDATA, 0);
        check("rst_len_err", len_err, 0);
        check("rst_irq", interrupt, 0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        #1;
        check("idle_in_ready", input_r_TREADY, 1);
        check("idle_cfg_ready", cfg_ready, 1);

        load_model(base0, base1, 0, 0);

        // Directed table: normal frames, tie rule, short and long frames.
        for (int i = 0; i < 6; i++) begin
            q = {};
            for (int k = 0; k < tbl[i].nb; k++) q.push_back(tbl[i].f[k]);
            exp_q.push_back(tbl[i].exp);
            run_frame(q, 0);
            check("len_err", len_err, tbl[i].lerr);
        end

        // Reset in the middle of a frame.
        input_r_TVALID = 1'b1;
        input_r_TLAST  = 1'b0;
        input_r_TDATA  = 32'd3;
        @(posedge ap_clk); #1;
        input_r_TDATA  = 32'd1;
        @(posedge ap_clk); #1;
        ap_rst         = 1'b1;
        input_r_TVALID = 1'b0;
        #1;
        check("midrst_in_ready", input_r_TREADY, 0);
        check("midrst_cfg_ready", cfg_ready, 0);
        check("midrst_tvalid", output_r_TVALID, 0);
        check("midrst_tdata", output_r_TDATA, 0);
        check("midrst_len_err", len_err, 0);
        @(posedge ap_clk); #1;
        check("midrst_hold_in_ready", input_r_TREADY, 0);
        ap_rst = 1'b0;
        #1;
        check("postrst_in_ready", input_r_TREADY, 1);
        q = {3, 1, 1, 1};
        exp_q.push_back(pack(0, 6));
        run_frame(q, 0);
        check("postrst_len_err", len_err, 0);

        // Out-of-range config writes must not disturb the loaded weights.
        cfg_write(2, 0, 32'd50, 1'b1);
        cfg_write(0, 5, 32'd50, 1'b1);
        q = {5, 0, 0, 0};
        exp_q.push_back(model(q));
        run_frame(q, 0);
        q = {0, 3, 0, 0};
        exp_q.push_back(model(q));
        run_frame(q, 0);

        // Negative bias steers the winner.
        cfg_write(0, 1, 0, 1'b1);
        cfg_write(0, 2, 0, 1'b1);
        cfg_write(0, 3, 0, 1'b1);
        cfg_write(0, N_FEAT, 32'hFFFF_FF9C, 1'b1);
        q = {127, 127, 127, 127};
        exp_q.push_back(pack(1, 254));
        run_frame(q, 0);

        // Positive saturation of the winning score.
        for (int i = 0; i < N_FEAT; i++) cfg_write(0, i, 32'h0000_7FFF, 1'b1);
        cfg_write(0, N_FEAT, 0, 1'b1);
        q = {32767, 32767, 32767, 32767};
        exp_q.push_back(pack(0, 24'h7FFFFF));
        run_frame(q, 0);

        // Output stall with a config write attempted during it.
        load_model(base0, base1, 0, 0);
        q = {3, 1, 1, 1};
        exp_q.push_back(model(q));
        run_frame(q, 10);
        q = {1, 0, 0, 0};
        exp_q.push_back(model(q));
        run_frame(q, 0);

        // Randomized frames against the reference model.
        for (int n = 0; n < 24; n++) begin
            if (n % 6 == 0) begin
                for (int i = 0; i < N_FEAT; i++) begin
                    rw0[i] = int'($urandom_range(127)) - 64;
                    rw1[i] = int'($urandom_range(127)) - 64;
                end
                load_model(rw0, rw1, int'($urandom_range(2000)) - 1000,
                           int'($urandom_range(2000)) - 1000);
            end
            q = {};
            for (int i = 0; i < N_FEAT; i++) q.push_back(int'($urandom_range(400)) - 200);
            exp_q.push_back(model(q));
            run_frame(q, int'($urandom_range(2)));
            check("rand_len_err", len_err, 0);
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
